// File: rtl/aes_pkg.sv
// Shared AES widths, FSM state types and GF(2^8) helpers for the streaming
// decrypt engine and its iterative AES-128 core.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_PUSH
  } stream_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_KEXP,
    CORE_DEC
  } core_state_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = gmul(a, a);
    t = gmul(t, a);
    for (int i = 0; i < 5; i++) t = gmul(gmul(t, t), a);
    return gmul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous FIFO for plaintext blocks plus their last flag. Also exposes
// the post-edge fill level so the producer can register its ready flag.
module aes_blk_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push & (count != DEPTH_CNT);
  assign do_pop     = pop & (count != '0);
  assign level_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign rvalid     = (count != '0);
  assign rdata      = rvalid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; an empty FIFO masks its read port,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= level_next;
    end
  end

endmodule

// File: rtl/aes_decryptor_top.sv
// Iterative single-shot AES-128 decryptor: 10 cycles of forward key expansion,
// then 10 inverse rounds using an on-the-fly reverse key schedule (L = 21).
module aes_decryptor_top
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [AES_BLOCK_W-1:0] ciphertext,
  output logic [AES_BLOCK_W-1:0] plaintext_out,
  output logic                   valid
);

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [7:0]   a [4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4]) ^
                               gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
    end
    return o;
  endfunction

  // InvShiftRows folded into the byte gather, then InvSubBytes and AddRoundKey.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(st[127-8*(r+4*((c-r+4)%4)) -: 8]) ^
                                rk[127-8*(r+4*c) -: 8];
    return mix ? inv_mix(o) : o;
  endfunction

  core_state_t      phase_q, phase_d;
  logic [3:0]       rnd_q;
  logic [127:0]     rk_q, st_q;
  logic [127:0]     rk_fwd, rk_bwd, round_st;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    phase_d = phase_q;
    case (phase_q)
      CORE_IDLE: if (start) phase_d = CORE_KEXP;
      CORE_KEXP: if (rnd_q == 4'd9) phase_d = CORE_DEC;
      CORE_DEC:  if (rnd_q == 4'd0) phase_d = CORE_IDLE;
      default:   phase_d = CORE_IDLE;
    endcase
  end

  always_comb begin
    rk_fwd   = key_fwd(rk_q, rcon(rnd_q));
    rk_bwd   = key_inv(rk_q, rcon(rnd_q));
    round_st = inv_round(st_q, rk_bwd, rnd_q != 4'd0);
  end

  // NOTE: registers use non-blocking assignment so every one of them updates
  // from the values that held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= CORE_IDLE;
      rnd_q         <= '0;
      rk_q          <= '0;
      st_q          <= '0;
      plaintext_out <= '0;
      valid         <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid   <= 1'b0;
      case (phase_q)
        CORE_IDLE: if (start) begin
          st_q  <= ciphertext;
          rk_q  <= key;
          rnd_q <= '0;
        end
        CORE_KEXP: begin
          rk_q <= rk_fwd;
          // Round-10 key is ready: apply the initial AddRoundKey and count back down.
          if (rnd_q == 4'd9) st_q <= st_q ^ rk_fwd;
          else               rnd_q <= rnd_q + 4'd1;
        end
        CORE_DEC: begin
          rk_q <= rk_bwd;
          st_q <= round_st;
          if (rnd_q == 4'd0) begin
            plaintext_out <= round_st;
            valid         <= 1'b1;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aes_cbc_decrypt_stream.sv
// Streaming AES-128 block decryptor with a plaintext FIFO. Define AES_CBC_EN
// for CBC chaining; otherwise blocks are decrypted independently (ECB).
module aes_cbc_decrypt_stream
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [AES_BLOCK_W-1:0] iv,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   out_last,
  output logic                   cfg_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  stream_state_t          state_q, state_d;
  logic                   in_ready_q;
  logic                   accept, cfg_ok;
  logic                   core_start, core_valid;
  logic [AES_BLOCK_W-1:0] core_pt;
  logic [AES_BLOCK_W-1:0] ct_q, pt_q, xor_term;
  logic                   last_q;
  logic [AES_KEY_W-1:0]   key_q;
  logic                   fifo_push, fifo_pop;
  logic [CNT_W-1:0]       level_next;
  logic [AES_BLOCK_W:0]   fifo_rdata;

  // Configuration wins over a block offered in the same cycle.
  assign in_ready = in_ready_q & ~cfg_load;
  assign accept   = in_valid & in_ready;
  assign cfg_ok   = cfg_load & (state_q == ST_IDLE);
  assign fifo_pop = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT:  if (core_valid) state_d = ST_PUSH;
      ST_PUSH:  begin
        fifo_push = 1'b1;
        state_d   = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ready reflects the post-edge state and fill level; in IDLE the level can
  // only fall, so the registered value never over-promises space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE) && (level_next < DEPTH_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q    <= '0;
      last_q  <= 1'b0;
      key_q   <= '0;
      pt_q    <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (accept) begin
        ct_q   <= in_data;
        last_q <= in_last;
      end
      if (cfg_ok) key_q <= key;
      if (cfg_load && (state_q != ST_IDLE)) cfg_err <= 1'b1;
      if ((state_q == ST_WAIT) && core_valid) pt_q <= core_pt;
    end
  end

`ifdef AES_CBC_EN
  logic [AES_BLOCK_W-1:0] iv_q, chain_q;

  // The chain restarts from the IV after the last block of each message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q    <= '0;
      chain_q <= '0;
    end else if (cfg_ok) begin
      iv_q    <= iv;
      chain_q <= iv;
    end else if (state_q == ST_PUSH) begin
      chain_q <= last_q ? iv_q : ct_q;
    end
  end

  assign xor_term = chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^iv;
  assign xor_term  = '0;
`endif

  aes_decryptor_top u_core (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (core_start),
    .key           (key_q),
    .ciphertext    (ct_q),
    .plaintext_out (core_pt),
    .valid         (core_valid)
  );

  aes_blk_fifo #(
    .WIDTH (AES_BLOCK_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .wdata      ({last_q, pt_q ^ xor_term}),
    .pop        (fifo_pop),
    .rdata      (fifo_rdata),
    .rvalid     (out_valid),
    .level_next (level_next)
  );

  assign out_last = fifo_rdata[AES_BLOCK_W];
  assign out_data = fifo_rdata[AES_BLOCK_W-1:0];

endmodule

// File: doc/aes_cbc_decrypt_stream.md
# aes_cbc_decrypt_stream

Streaming AES-128 decryption engine built around the existing iterative `aes_decryptor_top` core. Accepts a sequence of ciphertext blocks over a valid/ready handshake and issues one core decryption per block. Applies CBC chaining (optional, see Configuration) and buffers plaintext in a parametrised output FIFO. Sits between the host block interface and the single-shot decryptor; the next-generation replacement for driving the core directly with `start`/`valid`.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  one-cycle strobe; latches `key` and `iv`, resets chaining.
- `key`  in  128  AES-128 key, sampled on `cfg_load`.
- `iv`  in  128  CBC initial vector, sampled on `cfg_load`.
- `in_valid`  in  1  ciphertext block offered.
- `in_ready`  out  1  engine can accept a block.
- `in_data`  in  128  ciphertext block.
- `in_last`  in  1  block is the final block of a message.
- `out_valid`  out  1  plaintext block available.
- `out_ready`  in  1  consumer accepts the block.
- `out_data`  out  128  plaintext block.
- `out_last`  out  1  last flag travelling with the block.
- `cfg_err`  out  1  sticky; set when `cfg_load` arrives outside IDLE.

## Operation
- FSM states: IDLE, START, WAIT, PUSH.
- IDLE: `in_ready`=1 iff (FIFO count < FIFO_DEPTH). On `in_valid && in_ready`, capture `in_data`/`in_last` and go to START.
- START: drive core `start`=1 for exactly one cycle with captured ciphertext and latched key; go to WAIT.
- WAIT: core `valid` is a one-cycle completion pulse. On `valid`, register `plaintext_out`; go to PUSH.
- PUSH: write (plaintext XOR chain_reg, last) to FIFO. Update chain_reg to the captured ciphertext, or to latched `iv` if last=1. Return to IDLE.
- `cfg_load` in IDLE: latch key/iv, chain_reg := iv. In any other state: ignored, `cfg_err` set (cleared only by reset).
- `cfg_load` and `in_valid` in the same IDLE cycle: config applies first; the block is not accepted that cycle (`in_ready` forced 0).
- Only one block is in flight. FIFO space is checked at acceptance, so PUSH never finds the FIFO full.
- FIFO: `out_valid` = not empty. Pop on `out_valid && out_ready`. Simultaneous push and pop is allowed and leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH, with a count register width of clog2(FIFO_DEPTH)+1.

## Timing
- Reset (async assert, sync release): FSM=IDLE; key/iv/chain_reg=0; FIFO empty; `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `cfg_err`=0, core `start`=0.
- `in_ready` is registered; it rises on the first clock edge after `rst_n` release.
- Acceptance at edge T: `start` high during cycle T+1. Core `valid` arrives at T+1+L. PUSH at T+2+L. `out_valid` high at T+3+L when the FIFO was empty. Total latency is L+3.
- Block-to-block throughput: one block per L+3 cycles; `in_ready` is low from acceptance until PUSH completes.
- Back-pressure: with `out_ready`=0 and the FIFO full, `in_ready` stays 0. `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- Reset mid-operation: the in-flight block and FIFO contents are discarded; the core is reset via the shared `rst_n`.

## Configuration
- `AES_CBC_EN` defined: CBC decrypt, P_i = D(C_i) XOR C_{i-1}, with C_0 = iv; chain_reg logic and `iv` port are active.
- Not defined: ECB. The XOR term is forced to 0, chain_reg is removed, `iv` is accepted but unused, and `in_last` only propagates to `out_last`.

## Structure
- `aes_pkg`: `AES_BLOCK_W`=128, `AES_KEY_W`=128, FSM state typedef.
- Sub-module `aes_blk_fifo`: parametrised synchronous FIFO of width 129 (data + last) and depth FIFO_DEPTH. Instantiates `aes_decryptor_top` unchanged.

## Test plan
- Key 000102030405060708090A0B0C0D0E0F, iv=0, C=69C4E0D86A7B0430D8CDB78070B4C55A, last=1 → `out_data`=00112233445566778899AABBCCDDEEFF, `out_last`=1, latency L+3.
- CBC: iv=0, send the same C twice (last on the 2nd) → block1 00112233445566778899AABBCCDDEEFF; block2 69D5C2EB2E2E624750541D3BBC692BA5.
- CBC: iv=00112233445566778899AABBCCDDEEFF, single block → `out_data`=0. The next message then restarts from iv, giving the same result.
- Back-pressure: `out_ready`=0, send FIFO_DEPTH+1 blocks → exactly FIFO_DEPTH are accepted and `in_ready` stays 0. Release → in-order drain with stable data.
- `cfg_load` during WAIT → `cfg_err`=1, key unchanged, block output correct.
- `rst_n` pulsed low in WAIT → all outputs 0 immediately; after release a fresh vector decrypts correctly.
